move_picker: RTL and testbench

- Downstream consumer of the move generator's move RAM.
- When the generator signals moves_ready, the block walks move_index from 0 to move_count-1 and scores each resulting board by material balance. It keeps the best move for the side that moved, presents it on a valid/ack handshake, then pulses clear_moves so the generator re-arms.
- It is the first search/selection stage of the engine.

---
 rtl/vchess_pkg.sv | 41 ++++
 rtl/material_eval.sv | 35 +++
 rtl/move_picker.sv | 117 +++++++++++
 tb/tb_move_picker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vchess_pkg.sv
// vchess_pkg: shared piece codes, piece values, score type and square indexing.
`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 32
`endif
package vchess_pkg;
    localparam int PIECE_WIDTH = `PIECE_BITS;
    localparam int SIDE_WIDTH = PIECE_WIDTH * 8;
    localparam int BOARD_WIDTH = SIDE_WIDTH * 8;
    localparam int MAX_POSITIONS = `MAX_POSITIONS;
    localparam int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS);
    localparam int SCORE_WIDTH = 16;

    typedef logic signed [SCORE_WIDTH-1:0] score_t;

    localparam logic [PIECE_WIDTH-1:0] EMPTY_POSN = 0;
    localparam logic [PIECE_WIDTH-1:0] PAWN = 1;
    localparam logic [PIECE_WIDTH-1:0] KNIT = 2;
    localparam logic [PIECE_WIDTH-1:0] BISH = 3;
    localparam logic [PIECE_WIDTH-1:0] ROOK = 4;
    localparam logic [PIECE_WIDTH-1:0] QUEN = 5;
    localparam logic [PIECE_WIDTH-1:0] KING = 6;
    localparam logic [PIECE_WIDTH-1:0] BLACK_BIT = 8;

    localparam score_t PAWN_VALUE = 100;
    localparam score_t KNIGHT_VALUE = 300;
    localparam score_t BISHOP_VALUE = 300;
    localparam score_t ROOK_VALUE = 500;
    localparam score_t QUEEN_VALUE = 900;
    localparam score_t KING_VALUE = 0;
    localparam score_t CENTER_BONUS = 10;

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, RESULT, CLEAR, WAIT_LOW} state_t;

    // rank 0 is white's back rank, col 0 is the a-file
    function automatic int sq_index(input int rank, input int col);
        return rank * 8 + col;
    endfunction
endpackage

// File: rtl/material_eval.sv
// material_eval: combinational board-to-score, white positive.
// MOVE_PICKER_CENTER_BONUS_EN adds +-10 per pawn/knight on d4, e4, d5, e5.
module material_eval import vchess_pkg::*; (
    input  logic [BOARD_WIDTH-1:0] board,
    output score_t                 score
);
    function automatic score_t value_of(input logic [PIECE_WIDTH-1:0] p);
        logic [PIECE_WIDTH-1:0] t;
        score_t v;
        t = p & ~BLACK_BIT;
        v = t == PAWN ? PAWN_VALUE : t == KNIT ? KNIGHT_VALUE : t == BISH ? BISHOP_VALUE :
            t == ROOK ? ROOK_VALUE : t == QUEN ? QUEEN_VALUE : t == KING ? KING_VALUE : '0;
        return (p & BLACK_BIT) != '0 ? -v : v;
    endfunction

`ifdef MOVE_PICKER_CENTER_BONUS_EN
    function automatic score_t bonus_of(input logic [PIECE_WIDTH-1:0] p);
        logic [PIECE_WIDTH-1:0] t;
        t = p & ~BLACK_BIT;
        return (t == PAWN || t == KNIT) ? ((p & BLACK_BIT) != '0 ? -CENTER_BONUS : CENTER_BONUS) : '0;
    endfunction
`endif

    always_comb begin
        score = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                score = score + value_of(board[sq_index(r, c)*PIECE_WIDTH +: PIECE_WIDTH]);
`ifdef MOVE_PICKER_CENTER_BONUS_EN
                if ((r == 3 || r == 4) && (c == 3 || c == 4))
                    score = score + bonus_of(board[sq_index(r, c)*PIECE_WIDTH +: PIECE_WIDTH]);
`endif
            end
    end
endmodule

// File: rtl/move_picker.sv
// move_picker: scans the move RAM, keeps the best-scoring move for the side that moved.
// Center bonus scoring is enabled in material_eval by MOVE_PICKER_CENTER_BONUS_EN.
module move_picker import vchess_pkg::*; (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          moves_ready,
    input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
    input  logic [BOARD_WIDTH-1:0]        board_in,
    input  logic                          white_to_move_in,
    input  logic [3:0]                    castle_mask_in,
    input  logic [3:0]                    en_passant_col_in,
    output logic [MAX_POSITIONS_LOG2-1:0] move_index,
    output logic                          clear_moves,
    output logic                          best_valid,
    input  logic                          best_ack,
    output logic                          no_moves,
    output logic [MAX_POSITIONS_LOG2-1:0] best_index,
    output score_t                        best_score,
    output logic [BOARD_WIDTH-1:0]        best_board,
    output logic                          best_white_to_move,
    output logic [3:0]                    best_castle_mask,
    output logic [3:0]                    best_en_passant_col
);
    state_t state, state_next;
    logic [MAX_POSITIONS_LOG2-1:0] count_q, idx1, idx2;
    logic last_q, drain_q, d1, d2, first_q, mover, wtm_q, better;
    logic [3:0] castle_q, ep_q;
    logic [BOARD_WIDTH-1:0] board_q;
    score_t score_c, score_q;

    material_eval u_eval (.board(board_in), .score(score_c));

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = moves_ready ? (move_count == '0 ? RESULT : SCAN) : IDLE;
            SCAN:     state_next = last_q ? DRAIN : SCAN;
            DRAIN:    state_next = drain_q ? RESULT : DRAIN;
            RESULT:   state_next = best_ack ? CLEAR : RESULT;
            CLEAR:    state_next = WAIT_LOW;
            WAIT_LOW: state_next = moves_ready ? WAIT_LOW : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        best_valid = state == RESULT;
        clear_moves = state == CLEAR;
        better = first_q || (mover ? score_q > best_score : score_q < best_score);
    end

    // d1 marks board_in valid, d2 marks score_q valid; idx/board follow alongside
    always_ff @(posedge clk) begin
        idx1 <= move_index;
        idx2 <= idx1;
        score_q <= score_c;
        board_q <= board_in;
        wtm_q <= white_to_move_in;
        castle_q <= castle_mask_in;
        ep_q <= en_passant_col_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            move_index <= '0;
            count_q <= '0;
            last_q <= 1'b0;
            drain_q <= 1'b0;
            d1 <= 1'b0;
            d2 <= 1'b0;
            first_q <= 1'b0;
            mover <= 1'b0;
            no_moves <= 1'b0;
            best_index <= '0;
            best_score <= '0;
            best_board <= '0;
            best_white_to_move <= 1'b0;
            best_castle_mask <= '0;
            best_en_passant_col <= '0;
        end else begin
            d1 <= state == SCAN && !last_q;
            d2 <= d1;
            drain_q <= state == DRAIN && !drain_q;
            if (state == IDLE && moves_ready) begin
                move_index <= '0;
                count_q <= move_count;
                last_q <= 1'b0;
                first_q <= 1'b1;
                no_moves <= move_count == '0;
                best_index <= '0;
                best_score <= '0;
                best_board <= '0;
                best_white_to_move <= 1'b0;
                best_castle_mask <= '0;
                best_en_passant_col <= '0;
            end
            if (state == SCAN && !last_q) begin
                last_q <= move_index == count_q - 1'b1;
                if (move_index != count_q - 1'b1) move_index <= move_index + 1'b1;
            end
            // mover comes from entry 0, which always loads as the first candidate
            if (d2 && better) begin
                first_q <= 1'b0;
                mover <= first_q ? ~wtm_q : mover;
                best_index <= idx2;
                best_score <= score_q;
                best_board <= board_q;
                best_white_to_move <= wtm_q;
                best_castle_mask <= castle_q;
                best_en_passant_col <= ep_q;
            end
        end
    end
endmodule

// File: tb/tb_move_picker.sv
// tb_move_picker: directed scans against a RAM model, scoreboard-checked results.
module tb_move_picker;
    import vchess_pkg::*;
    localparam int BW = BOARD_WIDTH;
    localparam int PW = PIECE_WIDTH;
    localparam int L = MAX_POSITIONS_LOG2;
`ifdef MOVE_PICKER_CENTER_BONUS_EN
    localparam score_t CB = 10;
`else
    localparam score_t CB = 0;
`endif

    logic clk = 0, reset = 1, moves_ready = 0, best_ack = 0;
    logic [L-1:0] move_count = '0;
    logic [BW-1:0] board_in = '0;
    logic white_to_move_in = 0;
    logic [3:0] castle_mask_in = '0, en_passant_col_in = '0;
    logic [L-1:0] move_index, best_index;
    logic clear_moves, best_valid, no_moves, best_white_to_move;
    score_t best_score;
    logic [BW-1:0] best_board;
    logic [3:0] best_castle_mask, best_en_passant_col;

    move_picker dut (
        .clk(clk), .reset(reset), .moves_ready(moves_ready), .move_count(move_count),
        .board_in(board_in), .white_to_move_in(white_to_move_in), .castle_mask_in(castle_mask_in),
        .en_passant_col_in(en_passant_col_in), .move_index(move_index), .clear_moves(clear_moves),
        .best_valid(best_valid), .best_ack(best_ack), .no_moves(no_moves), .best_index(best_index),
        .best_score(best_score), .best_board(best_board), .best_white_to_move(best_white_to_move),
        .best_castle_mask(best_castle_mask), .best_en_passant_col(best_en_passant_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic nm;
        logic [L-1:0] idx;
        score_t score;
        logic [BW-1:0] board;
        logic wtm;
        logic [3:0] castle, ep;
        int lat, start;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0, n_fail = 0, cyc = 0, clr_cnt = 0;
    logic prev_v = 0;

    logic [BW-1:0] ram_b [MAX_POSITIONS];
    logic ram_w [MAX_POSITIONS];
    logic [3:0] ram_c [MAX_POSITIONS], ram_e [MAX_POSITIONS];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clear_moves) clr_cnt <= clr_cnt + 1;
        board_in <= ram_b[move_index];
        white_to_move_in <= ram_w[move_index];
        castle_mask_in <= ram_c[move_index];
        en_passant_col_in <= ram_e[move_index];
    end

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int sq, input logic [PW-1:0] p);
        b[sq*PW +: PW] = p;
        return b;
    endfunction

    function automatic logic [BW-1:0] start_board();
        logic [PW-1:0] back [8] = '{ROOK, KNIT, BISH, QUEN, KING, BISH, KNIT, ROOK};
        logic [BW-1:0] b = '0;
        for (int c = 0; c < 8; c++) begin
            b = put(b, sq_index(0, c), back[c]);
            b = put(b, sq_index(1, c), PAWN);
            b = put(b, sq_index(6, c), PAWN | BLACK_BIT);
            b = put(b, sq_index(7, c), back[c] | BLACK_BIT);
        end
        return b;
    endfunction

    task automatic entry(input int i, input logic [BW-1:0] b, input logic w, input logic [3:0] c, input logic [3:0] e);
        ram_b[i] = b; ram_w[i] = w; ram_c[i] = c; ram_e[i] = e;
    endtask

    function automatic exp_t mk(input logic nm, input int i, input score_t s, input int lat);
        exp_t e;
        e.nm = nm;
        e.idx = nm ? '0 : L'(i);
        e.score = s;
        e.board = nm ? '0 : ram_b[i];
        e.wtm = nm ? 1'b0 : ram_w[i];
        e.castle = nm ? 4'h0 : ram_c[i];
        e.ep = nm ? 4'h0 : ram_e[i];
        e.lat = lat;
        e.start = 0;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (best_valid && !prev_v) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_result: got best_index %0d expected none", best_index);
            end else begin
                e = sb.pop_front();
                chk("no_moves", BW'(no_moves), BW'(e.nm));
                chk("best_index", BW'(best_index), BW'(e.idx));
                chk("best_score", BW'({best_score}), BW'({e.score}));
                chk("best_board", best_board, e.board);
                chk("best_white_to_move", BW'(best_white_to_move), BW'(e.wtm));
                chk("best_castle_mask", BW'(best_castle_mask), BW'(e.castle));
                chk("best_en_passant_col", BW'(best_en_passant_col), BW'(e.ep));
                chk("latency", BW'(cyc - e.start), BW'(e.lat));
            end
        end
        prev_v = best_valid;
    end

    task automatic run(input int n, input exp_t e, input int hold, input bit wait_low);
        int c0;
        @(negedge clk);
        move_count = L'(n);
        moves_ready = 1;
        e.start = cyc;
        sb.push_back(e);
        c0 = clr_cnt;
        @(negedge clk);
        chk("start_index", BW'(move_index), BW'(0));
        move_count = ~move_count;
        for (int k = 0; k < 200 && !best_valid; k++) @(negedge clk);
        chk("valid_seen", BW'(best_valid), BW'(1));
        for (int k = 0; k < hold; k++) begin
            chk("hold_valid", BW'(best_valid), BW'(1));
            chk("hold_clear", BW'(clear_moves), BW'(0));
            chk("hold_index", BW'(best_index), BW'(e.idx));
            chk("hold_score", BW'({best_score}), BW'({e.score}));
            chk("hold_board", best_board, e.board);
            @(negedge clk);
        end
        best_ack = 1;
        @(negedge clk);
        best_ack = 0;
        chk("clear_pulse", BW'(clear_moves), BW'(1));
        chk("valid_drop", BW'(best_valid), BW'(0));
        @(negedge clk);
        chk("clear_single", BW'(clear_moves), BW'(0));
        if (wait_low)
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("wait_low_valid", BW'(best_valid), BW'(0));
                chk("wait_low_clear", BW'(clear_moves), BW'(0));
            end
        moves_ready = 0;
        @(negedge clk);
        @(negedge clk);
        chk("clear_count", BW'(clr_cnt - c0), BW'(1));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_move_index"}, BW'(move_index), BW'(0));
        chk({tag, "_clear_moves"}, BW'(clear_moves), BW'(0));
        chk({tag, "_best_valid"}, BW'(best_valid), BW'(0));
        chk({tag, "_no_moves"}, BW'(no_moves), BW'(0));
        chk({tag, "_best_index"}, BW'(best_index), BW'(0));
        chk({tag, "_best_score"}, BW'({best_score}), BW'(0));
        chk({tag, "_best_board"}, best_board, BW'(0));
        chk({tag, "_best_wtm"}, BW'(best_white_to_move), BW'(0));
        chk({tag, "_best_castle"}, BW'(best_castle_mask), BW'(0));
        chk({tag, "_best_ep"}, BW'(best_en_passant_col), BW'(0));
    endtask

    task automatic load_white_queen();
        entry(0, start_board(), 0, 4'hf, 4'h8);
        entry(1, put(start_board(), 48, EMPTY_POSN), 0, 4'h3, 4'h0);
        entry(2, put(start_board(), 59, EMPTY_POSN), 0, 4'ha, 4'h5);
    endtask

    initial begin
        int c0;
        for (int i = 0; i < MAX_POSITIONS; i++) entry(i, '0, 0, 4'h0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 0;

        // one white pawn move e2-e4 from the start position
        entry(0, put(put(start_board(), 12, EMPTY_POSN), 28, PAWN), 0, 4'hf, 4'h4);
        run(1, mk(0, 0, CB, 5), 0, 0);

        // black mover keeps the minimum; tie at -300 goes to index 1
        entry(0, start_board(), 1, 4'hf, 4'h8);
        entry(1, put(start_board(), 1, EMPTY_POSN), 1, 4'h1, 4'h2);
        entry(2, put(start_board(), 2, EMPTY_POSN), 1, 4'h2, 4'h3);
        entry(3, put(start_board(), 48, EMPTY_POSN), 1, 4'h4, 4'h6);
        run(4, mk(0, 1, -300, 8), 0, 0);

        // white mover, queen capture wins; result held 50 cycles before ack
        load_white_queen();
        run(3, mk(0, 2, 900, 7), 50, 0);

        // white mover tie at +100 keeps index 0
        entry(0, put(start_board(), 48, EMPTY_POSN), 0, 4'h7, 4'h1);
        entry(1, put(start_board(), 55, EMPTY_POSN), 0, 4'h6, 4'h7);
        entry(2, start_board(), 0, 4'h5, 4'h2);
        run(3, mk(0, 0, 100, 7), 0, 0);

        // zero moves, then hold moves_ready high in WAIT_LOW
        run(0, mk(1, 0, 0, 1), 0, 1);

        // reset mid-scan abandons it without a clear pulse
        for (int i = 3; i < 8; i++) entry(i, start_board(), 0, 4'h0, 4'h0);
        load_white_queen();
        @(negedge clk);
        move_count = L'(8);
        moves_ready = 1;
        c0 = clr_cnt;
        repeat (5) @(negedge clk);
        reset = 1;
        moves_ready = 0;
        @(negedge clk);
        check_zero("midscan");
        reset = 0;
        @(negedge clk);
        chk("midscan_no_clear", BW'(clr_cnt - c0), BW'(0));
        run(3, mk(0, 2, 900, 7), 0, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", BW'(sb.size()), BW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
